// File: rtl/mode_switch_pkg.sv
// Shared state encoding and default timing values for the HF/LF mode switch controller.
package mode_switch_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StDebounce,
    StWaitQuiet,
    StBlank,
    StSwap,
    StSettle
  } state_e;

  localparam int unsigned DebCyclesDef    = 240;
  localparam int unsigned SettleCyclesDef = 48;
  localparam int unsigned QuietTimeoutDef = 24000;

  // Width of a counter able to hold the largest of the three terminal counts.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/mode_sync.sv
// Two-flop synchroniser bringing the asynchronous mode pin into the pck0 domain.
module mode_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/mode_switch_ctrl.sv
// HF/LF mode switch sequencer: debounce, wait for an idle bus, blank, swap, settle.
// Define MODE_SWITCH_TIMEOUT_EN to force the swap after QUIET_TIMEOUT cycles of a busy bus.
module mode_switch_ctrl
  import mode_switch_pkg::*;
#(
  parameter int unsigned DEB_CYCLES    = DebCyclesDef,
  parameter int unsigned SETTLE_CYCLES = SettleCyclesDef,
  parameter int unsigned QUIET_TIMEOUT = QuietTimeoutDef
) (
  input  logic       pck0,
  input  logic       nrst,
  input  logic       fpga_switch_raw,
  input  logic       ncs,
  input  logic       ssp_frame,
  output logic       mode_sel,
  output logic       blank,
  output logic       hf_rst_n,
  output logic       lf_rst_n,
  output logic       busy,
  output logic [7:0] switch_cnt,
  output logic       timeout_flag
);

  localparam int unsigned CntW = cnt_width(DEB_CYCLES, SETTLE_CYCLES, QUIET_TIMEOUT);

  logic sw_s;

  mode_sync u_sync (
    .clk   (pck0),
    .rst_n (nrst),
    .d     (fpga_switch_raw),
    .q     (sw_s)
  );

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              mode_sel_q, mode_sel_d;
  logic              blank_q, blank_d;
  logic              hf_rst_n_q, hf_rst_n_d;
  logic              lf_rst_n_q, lf_rst_n_d;
  logic [7:0]        switch_cnt_q, switch_cnt_d;
  logic              mismatch, quiet, open;

  assign mismatch = (sw_s != mode_sel_q);
  assign quiet    = ncs && !ssp_frame;

`ifdef MODE_SWITCH_TIMEOUT_EN
  logic timeout_q, timeout_d;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mode_sel_d   = mode_sel_q;
    switch_cnt_d = switch_cnt_q;
`ifdef MODE_SWITCH_TIMEOUT_EN
    timeout_d    = timeout_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (mismatch) begin
          state_d = StDebounce;
          cnt_d   = '0;
        end
      end
      StDebounce: begin
        if (!mismatch) begin
          state_d = StIdle;
        end else if (cnt_q == CntW'(DEB_CYCLES - 1)) begin
          state_d = StWaitQuiet;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWaitQuiet: begin
        if (!mismatch) begin
          state_d = StIdle;
        end else if (quiet) begin
          state_d = StBlank;
`ifdef MODE_SWITCH_TIMEOUT_EN
        end else if (cnt_q == CntW'(QUIET_TIMEOUT - 1)) begin
          state_d   = StBlank;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      StBlank: state_d = StSwap;
      StSwap: begin
        mode_sel_d   = ~mode_sel_q;
        switch_cnt_d = switch_cnt_q + 8'd1;
        state_d      = StSettle;
        cnt_d        = '0;
      end
      StSettle: begin
        if (cnt_q == CntW'(SETTLE_CYCLES - 1)) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StSettle;
        cnt_d   = '0;
      end
    endcase

    // Outputs are registered from the next state so the antenna and core resets never glitch.
    open       = state_d inside {StIdle, StDebounce, StWaitQuiet};
    blank_d    = !open;
    hf_rst_n_d = open && mode_sel_d;
    lf_rst_n_d = open && !mode_sel_d;
  end

  always_ff @(posedge pck0 or negedge nrst) begin
    if (!nrst) begin
      state_q      <= StSettle;
      cnt_q        <= '0;
      mode_sel_q   <= 1'b0;
      blank_q      <= 1'b1;
      hf_rst_n_q   <= 1'b0;
      lf_rst_n_q   <= 1'b0;
      switch_cnt_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mode_sel_q   <= mode_sel_d;
      blank_q      <= blank_d;
      hf_rst_n_q   <= hf_rst_n_d;
      lf_rst_n_q   <= lf_rst_n_d;
      switch_cnt_q <= switch_cnt_d;
    end
  end

`ifdef MODE_SWITCH_TIMEOUT_EN
  always_ff @(posedge pck0 or negedge nrst) begin
    if (!nrst) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_d;
    end
  end

  assign timeout_flag = timeout_q;
`else
  assign timeout_flag = 1'b0;
`endif

  assign mode_sel   = mode_sel_q;
  assign blank      = blank_q;
  assign hf_rst_n   = hf_rst_n_q;
  assign lf_rst_n   = lf_rst_n_q;
  assign switch_cnt = switch_cnt_q;
  assign busy       = (state_q != StIdle);

endmodule
